// File: rtl/sram_mem_controller_if.sv
// MEM-stage request/response bundle for the off-chip SRAM controller.
//   rd_en, wr_en  : load/store request, held stable while ready=0
//   address       : 1024-based byte address from the ALU
//   write_data    : store data, held stable while ready=0
//   read_data     : load data, valid in the cycle ready rises
//   ready         : 1 = no transfer pending, 0 = freeze IF..MEM
// master = pipeline side, slave = controller side.
interface sram_mem_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit MEM-stage access into two 16-bit asynchronous SRAM
// transfers (low half first), stalling the pipeline via ready while busy.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous, active-low reset
//   mem        : MEM-stage request/response bundle (slave side)
//   SRAM_ADDR  : half-word address to the SRAM
//   SRAM_DQ    : bidirectional SRAM data bus
//   SRAM_WE_N  : SRAM write enable, active-low
// Parameters:
//   WAIT_CYCLES : clock cycles per half-word phase (1..15)
//   SRAM_AW     : SRAM address width in half-words
module sram_mem_controller #(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic                clk,
  input  logic                rst,
  sram_mem_controller_if.slave mem,
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  inout  wire  [15:0]         SRAM_DQ,
  output logic                SRAM_WE_N
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] LAST   = 4'(WAIT_CYCLES - 1);
  localparam bit         SINGLE = (WAIT_CYCLES == 1);

  state_t              state, state_next;
  logic [3:0]          cnt;
  logic                op_wr;
  logic [31:0]         rdata;
  logic [31:0]         addr_off;
  logic [SRAM_AW-2:0]  word;
  logic                req;
  logic                last;
  logic                dq_oe;
  logic [15:0]         dq_out;
  logic                unused_addr;

  assign req      = mem.rd_en | mem.wr_en;
  assign last     = (cnt == LAST);
  assign addr_off = mem.address - 32'd1024;
  // Word index bits above the SRAM range are dropped, so accesses wrap.
  assign word        = addr_off[SRAM_AW:2];
  assign unused_addr = ^{addr_off[31:SRAM_AW+1], addr_off[1:0]};

  assign mem.read_data = rdata;
  assign SRAM_DQ       = dq_oe ? dq_out : 'z;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (req)  state_next = LO;
      LO:   if (last) state_next = HI;
      HI:   if (last) state_next = DONE;
      DONE:           state_next = IDLE;
      default:        state_next = IDLE;
    endcase
  end

  always_comb begin
    mem.ready = 1'b0;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = mem.write_data[15:0];
    unique case (state)
      IDLE: mem.ready = ~req;
      DONE: mem.ready = 1'b1;
      LO, HI: begin
        if (op_wr) begin
          dq_oe  = 1'b1;
          dq_out = (state == HI) ? mem.write_data[31:16] : mem.write_data[15:0];
          // WE_N rises on the last phase cycle so data is held past the
          // rising edge; a single-cycle phase keeps it low throughout.
          SRAM_WE_N = ~(SINGLE || !last);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      op_wr     <= 1'b0;
      rdata     <= '0;
      SRAM_ADDR <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (req) begin
            op_wr     <= mem.wr_en;
            SRAM_ADDR <= {word, 1'b0};
          end
        end
        LO: begin
          if (last) begin
            cnt          <= '0;
            SRAM_ADDR[0] <= 1'b1;
            if (!op_wr) rdata[15:0] <= SRAM_DQ;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HI: begin
          if (last) begin
            cnt <= '0;
            if (!op_wr) rdata[31:16] <= SRAM_DQ;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

endmodule
